// File: rtl/source_sweep.sv
// Exhaustive sweep driver for a 2-input, 2-bit function: drives all 16 (a,b) pairs,
// samples c after a settle delay, and builds a packed truth table plus value histogram.
module source_sweep #(
   parameter int SETTLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [1:0]  a_out,
   output logic [1:0]  b_out,
   input  logic [1:0]  c_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [4:0]  cnt0,
   output logic [4:0]  cnt1,
   output logic [4:0]  cnt2,
   output logic [4:0]  cnt3
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DRIVE  = 2'd1;
   localparam logic [1:0] SAMPLE = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   logic [1:0] state;
   logic [3:0] idx;
   logic [3:0] settle_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= 4'd0;
         settle_cnt <= 4'd0;
         result     <= 32'd0;
         cnt0       <= 5'd0;
         cnt1       <= 5'd0;
         cnt2       <= 5'd0;
         cnt3       <= 5'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               // A finished sweep stays readable until the next start is accepted
               if (start) begin
                  state      <= DRIVE;
                  idx        <= 4'd0;
                  settle_cnt <= 4'd0;
                  result     <= 32'd0;
                  cnt0       <= 5'd0;
                  cnt1       <= 5'd0;
                  cnt2       <= 5'd0;
                  cnt3       <= 5'd0;
               end
            end
            DRIVE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state      <= SAMPLE;
                  settle_cnt <= 4'd0;
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end
            SAMPLE: begin
               result[{idx, 1'b0} +: 2] <= c_in;
               case (c_in)
                  2'd0:    cnt0 <= cnt0 + 5'd1;
                  2'd1:    cnt1 <= cnt1 + 5'd1;
                  2'd2:    cnt2 <= cnt2 + 5'd1;
                  default: cnt3 <= cnt3 + 5'd1;
               endcase
               if (idx == 4'd15) begin
                  state <= DONE;
               end else begin
                  idx   <= idx + 4'd1;
                  state <= DRIVE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign a_out = idx[3:2];
   assign b_out = idx[1:0];
   assign busy  = (state == DRIVE) || (state == SAMPLE);
   assign done  = (state == DONE);

endmodule
